// File: rtl/nios_system_carcontrol_nios_ocimem_arbiter.sv
// OCI debug RAM sequencer: captures JTAG strobes into a one-deep slot and
// shares the single RAM port with CPU debug-slave accesses (round-robin).
module nios_system_carcontrol_nios_ocimem_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_J_ACC,
    ST_J_WAIT,
    ST_C_ACC,
    ST_C_WAIT
  } state_t;

  typedef enum logic {
    GNT_C,
    GNT_J
  } grant_t;

  state_t              state_q, state_d;
  grant_t              last_grant_q, last_grant_d;
  logic                slot_vld_q, slot_vld_d;
  logic                slot_rd_q, slot_rd_d;
  logic [ADDR_W-1:0]   slot_addr_q, slot_addr_d;
  logic [DATA_W-1:0]   slot_data_q, slot_data_d;
  logic [ADDR_W-1:0]   jtag_addr_q, jtag_addr_d;
  logic [DATA_W-1:0]   mon_dreg_q, mon_dreg_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;

  logic                c_req;
  logic                slot_free;
  logic                slot_full_eff;
  logic                unused_jdo;

  assign c_req      = avs_read | avs_write;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign MonDReg      = mon_dreg_q;
  assign jtag_busy    = busy_q;
  assign jtag_overrun = overrun_q;

  // Next-state, RAM/slave port decode, and JTAG strobe capture.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    slot_vld_d      = slot_vld_q;
    slot_rd_d       = slot_rd_q;
    slot_addr_d     = slot_addr_q;
    slot_data_d     = slot_data_q;
    jtag_addr_d     = jtag_addr_q;
    mon_dreg_d      = mon_dreg_q;
    overrun_d       = overrun_q;
    busy_d          = busy_q;
    slot_free       = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;
    ram_we          = 1'b0;
    ram_re          = 1'b0;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;

    case (state_q)
      ST_IDLE: begin
        // JTAG wins when it is alone or when the CPU had the last grant.
        if (slot_vld_q && (!c_req || last_grant_q == GNT_C)) begin
          state_d      = ST_J_ACC;
          last_grant_d = GNT_J;
        end else if (c_req) begin
          state_d      = ST_C_ACC;
          last_grant_d = GNT_C;
        end
      end
      ST_J_ACC: begin
        ram_addr = slot_addr_q;
        if (slot_rd_q) begin
          ram_re  = 1'b1;
          state_d = ST_J_WAIT;
        end else begin
          ram_we    = 1'b1;
          ram_wdata = slot_data_q;
          slot_free = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_J_WAIT: begin
        mon_dreg_d = ram_rdata;
        slot_free  = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_C_ACC: begin
        ram_addr = avs_address;
        if (avs_write) begin
          ram_we          = 1'b1;
          ram_wdata       = avs_writedata;
          avs_waitrequest = 1'b0;
          state_d         = ST_IDLE;
        end else if (avs_read) begin
          ram_re  = 1'b1;
          state_d = ST_C_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_C_WAIT: begin
        avs_readdata    = ram_rdata;
        avs_waitrequest = 1'b0;
        state_d         = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A slot being freed this cycle can accept a new strobe in the same edge.
    if (slot_free) begin
      slot_vld_d = 1'b0;
    end
    slot_full_eff = slot_vld_q & ~slot_free;

    // Strobe priority: write > read > address load; losers flag an overrun.
    if (take_action_ocimem_b) begin
      if (slot_full_eff) begin
        overrun_d = 1'b1;
      end else begin
        slot_vld_d  = 1'b1;
        slot_rd_d   = 1'b0;
        slot_addr_d = jtag_addr_q;
        slot_data_d = jdo[34:3];
        jtag_addr_d = jtag_addr_q + ADDR_W'(1);
      end
      if (take_no_action_ocimem_a || take_action_ocimem_a) begin
        overrun_d = 1'b1;
      end
    end else if (take_no_action_ocimem_a) begin
      if (slot_full_eff) begin
        overrun_d = 1'b1;
      end else begin
        slot_vld_d  = 1'b1;
        slot_rd_d   = 1'b1;
        slot_addr_d = jtag_addr_q;
        slot_data_d = jdo[34:3];
        jtag_addr_d = jtag_addr_q + ADDR_W'(1);
      end
      if (take_action_ocimem_a) begin
        overrun_d = 1'b1;
      end
    end else if (take_action_ocimem_a) begin
      jtag_addr_d = jdo[ADDR_W+16:17];
      overrun_d   = 1'b0;
    end

    busy_d = slot_vld_d | (state_d == ST_J_ACC) | (state_d == ST_J_WAIT);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_C;
      slot_vld_q   <= 1'b0;
      slot_rd_q    <= 1'b0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      jtag_addr_q  <= '0;
      mon_dreg_q   <= '0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      slot_vld_q   <= slot_vld_d;
      slot_rd_q    <= slot_rd_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      jtag_addr_q  <= jtag_addr_d;
      mon_dreg_q   <= mon_dreg_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_nios_system_carcontrol_nios_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter with a behavioural 1-cycle RAM.
module tb_nios_system_carcontrol_nios_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [37:0] jdo;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        jtag_busy;
  logic        jtag_overrun;

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  nios_system_carcontrol_nios_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .jdo                     (jdo),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_we                  (ram_we),
    .ram_re                  (ram_re),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .jtag_busy               (jtag_busy),
    .jtag_overrun            (jtag_overrun)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_load(input logic [7:0] a);
    take_action_ocimem_a = 1'b1;
    jdo = 38'(a) << 17;
    tick();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
  endtask

  task automatic jtag_wr(input logic [31:0] d);
    take_action_ocimem_b = 1'b1;
    jdo = 38'(d) << 3;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    chk("jwr_busy", 32'(jtag_busy), 32'd1);
    tick();
    chk("jwr_we", 32'(ram_we), 32'd1);
    chk("jwr_wdata", ram_wdata, d);
    tick();
  endtask

  task automatic jtag_rd(input logic [31:0] exp, input logic [31:0] old);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick();
    chk("jrd_re", 32'(ram_re), 32'd1);
    tick();
    chk("jrd_mon_old", MonDReg, old);
    tick();
    chk("jrd_mon_new", MonDReg, exp);
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
    avs_write = 1'b1;
    avs_address = a;
    avs_writedata = d;
    chk("cwr_wait_c0", 32'(avs_waitrequest), 32'd1);
    tick();
    chk("cwr_wait_c1", 32'(avs_waitrequest), 32'd0);
    chk("cwr_we", 32'(ram_we), 32'd1);
    chk("cwr_addr", 32'(ram_addr), 32'(a));
    tick();
    avs_write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a, input logic [31:0] exp);
    avs_read = 1'b1;
    avs_address = a;
    tick();
    chk("crd_wait_c1", 32'(avs_waitrequest), 32'd1);
    chk("crd_re", 32'(ram_re), 32'd1);
    tick();
    chk("crd_wait_c2", 32'(avs_waitrequest), 32'd0);
    chk("crd_data", avs_readdata, exp);
    tick();
    avs_read = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = '0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;

    // Reset values, during and after reset.
    tick();
    tick();
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_re", 32'(ram_re), 32'd0);
    chk("rst_wait", 32'(avs_waitrequest), 32'd1);
    chk("rst_rdata", avs_readdata, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_mon", MonDReg, 32'd0);
    chk("post_rst_busy", 32'(jtag_busy), 32'd0);
    chk("post_rst_ovr", 32'(jtag_overrun), 32'd0);
    chk("post_rst_wait", 32'(avs_waitrequest), 32'd1);
    chk("post_rst_we", 32'(ram_we), 32'd0);

    // CPU write then read.
    cpu_wr(8'h10, 32'hDEADBEEF);
    cpu_rd(8'h10, 32'hDEADBEEF);

    // JTAG auto-increment with address wrap.
    jtag_load(8'hFE);
    jtag_wr(32'h11111111);
    jtag_wr(32'h22222222);
    jtag_wr(32'h33333333);
    chk("mem_fe", mem[8'hFE], 32'h11111111);
    chk("mem_ff", mem[8'hFF], 32'h22222222);
    chk("mem_00", mem[8'h00], 32'h33333333);
    jtag_load(8'hFE);
    jtag_rd(32'h11111111, 32'h00000000);
    jtag_rd(32'h22222222, 32'h11111111);
    jtag_rd(32'h33333333, 32'h22222222);
    chk("jrd_idle_busy", 32'(jtag_busy), 32'd0);

    // Overrun: read strobes on consecutive cycles.
    jtag_load(8'hFE);
    take_no_action_ocimem_a = 1'b1;
    tick();
    tick();
    take_no_action_ocimem_a = 1'b0;
    chk("ovr_flag", 32'(jtag_overrun), 32'd1);
    chk("ovr_re", 32'(ram_re), 32'd1);
    chk("ovr_addr", 32'(ram_addr), 32'h000000FE);
    tick();
    tick();
    chk("ovr_mon", MonDReg, 32'h11111111);
    chk("ovr_busy", 32'(jtag_busy), 32'd0);
    jtag_rd(32'h22222222, 32'h11111111);
    chk("ovr_sticky", 32'(jtag_overrun), 32'd1);
    jtag_load(8'h00);
    chk("ovr_clear", 32'(jtag_overrun), 32'd0);

    // Same-cycle write and read strobes: only the write happens.
    jtag_load(8'h30);
    take_action_ocimem_b = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    jdo = 38'(32'h5A5A5A5A) << 3;
    tick();
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = '0;
    chk("dual_ovr", 32'(jtag_overrun), 32'd1);
    tick();
    chk("dual_we", 32'(ram_we), 32'd1);
    chk("dual_re", 32'(ram_re), 32'd0);
    chk("dual_addr", 32'(ram_addr), 32'h00000030);
    chk("dual_wdata", ram_wdata, 32'h5A5A5A5A);
    tick();
    chk("dual_mem", mem[8'h30], 32'h5A5A5A5A);
    chk("dual_busy", 32'(jtag_busy), 32'd0);
    chk("dual_mon", MonDReg, 32'h22222222);

    // Contention from reset: JTAG first, then CPU.
    reset_n = 1'b0;
    tick();
    chk("rst2_mon", MonDReg, 32'd0);
    reset_n = 1'b1;
    tick();
    take_action_ocimem_b = 1'b1;
    jdo = 38'(32'hAAAA0001) << 3;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    avs_write = 1'b1;
    avs_address = 8'h20;
    avs_writedata = 32'hCCCC0001;
    tick();
    chk("cont1_j_we", 32'(ram_we), 32'd1);
    chk("cont1_j_addr", 32'(ram_addr), 32'h00000000);
    chk("cont1_j_wdata", ram_wdata, 32'hAAAA0001);
    chk("cont1_c_wait", 32'(avs_waitrequest), 32'd1);
    tick();
    chk("cont1_idle_wait", 32'(avs_waitrequest), 32'd1);
    tick();
    chk("cont1_c_go", 32'(avs_waitrequest), 32'd0);
    chk("cont1_c_addr", 32'(ram_addr), 32'h00000020);
    chk("cont1_c_wdata", ram_wdata, 32'hCCCC0001);
    tick();
    avs_write = 1'b0;

    // Lone JTAG write leaves JTAG as last grant; next contention favours CPU.
    jtag_wr(32'hAAAA0002);
    take_action_ocimem_b = 1'b1;
    jdo = 38'(32'hAAAA0003) << 3;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    avs_write = 1'b1;
    avs_address = 8'h21;
    avs_writedata = 32'hCCCC0002;
    tick();
    chk("cont2_c_go", 32'(avs_waitrequest), 32'd0);
    chk("cont2_c_we", 32'(ram_we), 32'd1);
    chk("cont2_c_addr", 32'(ram_addr), 32'h00000021);
    tick();
    avs_write = 1'b0;
    chk("cont2_j_busy", 32'(jtag_busy), 32'd1);
    tick();
    chk("cont2_j_we", 32'(ram_we), 32'd1);
    chk("cont2_j_addr", 32'(ram_addr), 32'h00000002);
    chk("cont2_j_wdata", ram_wdata, 32'hAAAA0003);
    chk("cont2_j_wait", 32'(avs_waitrequest), 32'd1);
    tick();
    chk("cont_mem00", mem[8'h00], 32'hAAAA0001);
    chk("cont_mem01", mem[8'h01], 32'hAAAA0002);
    chk("cont_mem02", mem[8'h02], 32'hAAAA0003);
    chk("cont_mem20", mem[8'h20], 32'hCCCC0001);
    chk("cont_mem21", mem[8'h21], 32'hCCCC0002);

    // Reset asserted during a JTAG write access.
    cpu_wr(8'h50, 32'h0BADF00D);
    jtag_load(8'h50);
    take_action_ocimem_b = 1'b1;
    jdo = 38'(32'h12345678) << 3;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    tick();
    chk("midrst_we_pre", 32'(ram_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_we", 32'(ram_we), 32'd0);
    chk("midrst_busy", 32'(jtag_busy), 32'd0);
    chk("midrst_wait", 32'(avs_waitrequest), 32'd1);
    tick();
    chk("midrst_mem", mem[8'h50], 32'h0BADF00D);
    reset_n = 1'b1;
    tick();
    chk("midrst_post_we", 32'(ram_we), 32'd0);
    chk("midrst_post_busy", 32'(jtag_busy), 32'd0);
    chk("midrst_post_ovr", 32'(jtag_overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
